dfe_out_capture: RTL

//  Consumer end of the DFE output interface: captures the signed DFE result word OUT on each
//  OUT_CLK rising edge into an on-chip buffer, then shifts the buffered record off-chip over a
//  1-bit serial port for tester readout. Sits beside ADC_DFE at chip top, clocked from CLK_adc1.

---
 rtl/dfe_out_capture_pkg.sv | 21 ++
 rtl/dfe_out_capture_ram.sv | 32 +++
 rtl/dfe_out_capture.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/dfe_out_capture_pkg.sv
// Shared definitions for the DFE output capture block: default geometry and FSM codes.
package dfe_out_capture_pkg;

  // Default geometry: ADC code width, derived DFE word width, buffer depth and address width.
  localparam int unsigned BW_DEF    = 6;
  localparam int unsigned DW_DEF    = BW_DEF + 15;
  localparam int unsigned DEPTH_DEF = 64;
  localparam int unsigned AW_DEF    = 6;

  // Controller state encodings (kept as plain 2-bit constants for legacy tools).
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CAPTURE = 2'd1;
  localparam logic [1:0] S_FULL    = 2'd2;
  localparam logic [1:0] S_SHIFT   = 2'd3;

  // A state that owns the buffer, i.e. one in which capture or readout is running.
  function automatic logic state_is_busy(input logic [1:0] st);
    return (st == S_CAPTURE) || (st == S_SHIFT);
  endfunction

endpackage

// File: rtl/dfe_out_capture_ram.sv
// Capture buffer: simple dual-port synchronous RAM, one write port and one registered
// read port (1-cycle latency), no reset. Interchangeable with a foundry SRAM macro of the same ports.
module dfe_out_capture_ram #(
  parameter int DW    = 21,
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          i_clk,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [DW-1:0] i_wr_data,
  input  logic          i_rd_en,
  input  logic [AW-1:0] i_rd_addr,
  output logic [DW-1:0] o_rd_data
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rd_data;

  // Array write and registered read; the read data holds until the next read enable.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/dfe_out_capture.sv
// Consumer end of the DFE output interface: captures one signed DFE word per OUT_CLK rising
// edge into a buffer, then shifts the full record out MSB-first over a 1-bit serial port.
module dfe_out_capture
  import dfe_out_capture_pkg::*;
#(
  parameter  int BW    = BW_DEF,
  parameter  int DEPTH = DEPTH_DEF,
  parameter  int AW    = AW_DEF,
  localparam int DW    = BW + 15
) (
  input  logic          CLK,
  input  logic          RES,
  input  logic          OUT_CLK,
  input  logic [DW-1:0] OUT,
  input  logic          ARM,
  input  logic          RD_START,
  output logic          DONE,
  output logic          BUSY,
  output logic [AW:0]   COUNT,
  output logic          SDO,
  output logic          SFRAME,
  output logic          SVALID
);

  localparam int            BIW       = $clog2(DW);
  localparam logic [BIW-1:0] TOP_BIT  = BIW'(DW - 1);
  localparam logic [AW-1:0]  LAST_ADDR = AW'(DEPTH - 1);

  logic [1:0]     r_state;
  logic           r_out_clk_q;
  logic [AW-1:0]  r_wr_ptr;
  logic [AW:0]    r_count;
  logic [AW-1:0]  r_rd_ptr;
  logic [BIW-1:0] r_bit_idx;
  logic           r_drain;
  logic           r_done;
  logic           r_busy;
  logic           r_sdo;
  logic           r_sframe;
  logic           r_svalid;

  logic           w_strb;
  logic           w_wr_en;
  logic           w_rd_en;
  logic [AW-1:0]  w_rd_addr;
  logic [DW-1:0]  w_ram_q;
  logic           w_last_bit;
  logic           w_last_word;

  assign w_strb      = OUT_CLK & ~r_out_clk_q;
  assign w_last_bit  = (r_bit_idx == {BIW{1'b0}});
  assign w_last_word = (r_rd_ptr == LAST_ADDR);
  // ARM in the same cycle as a strobe wins: the word is dropped.
  assign w_wr_en     = ~RES & (r_state == S_CAPTURE) & w_strb & ~ARM;

  // Read port control: fetch word 0 when readout is accepted, and prefetch the next word
  // while the current word's LSB is being launched so the bit stream has no gaps.
  always_comb begin
    w_rd_en   = 1'b0;
    w_rd_addr = {AW{1'b0}};
    if (RES) begin
      w_rd_en = 1'b0;
    end else if ((r_state == S_FULL) && RD_START && !ARM) begin
      w_rd_en = 1'b1;
    end else if ((r_state == S_SHIFT) && !r_drain && w_last_bit && !w_last_word) begin
      w_rd_en   = 1'b1;
      w_rd_addr = r_rd_ptr + AW'(1);
    end else begin
      w_rd_en = 1'b0;
    end
  end

  dfe_out_capture_ram #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .i_clk     (CLK),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (OUT),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_ram_q)
  );

  // Controller: strobe edge history, capture pointers, readout bit counter and serial outputs.
  always_ff @(posedge CLK) begin
    if (RES) begin
      r_state     <= S_IDLE;
      r_out_clk_q <= 1'b0;
      r_wr_ptr    <= {AW{1'b0}};
      r_count     <= {(AW+1){1'b0}};
      r_rd_ptr    <= {AW{1'b0}};
      r_bit_idx   <= {BIW{1'b0}};
      r_drain     <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_sdo       <= 1'b0;
      r_sframe    <= 1'b0;
      r_svalid    <= 1'b0;
    end else begin
      r_out_clk_q <= OUT_CLK;
      case (r_state)
        S_IDLE: begin
          if (ARM) begin
            r_state  <= S_CAPTURE;
            r_wr_ptr <= {AW{1'b0}};
            r_count  <= {(AW+1){1'b0}};
            r_busy   <= 1'b1;
          end
        end
        S_CAPTURE: begin
          if (ARM) begin
            r_wr_ptr <= {AW{1'b0}};
            r_count  <= {(AW+1){1'b0}};
          end else if (w_strb) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
            r_count  <= r_count + (AW+1)'(1);
            if (r_wr_ptr == LAST_ADDR) begin
              r_state <= S_FULL;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end
          end
        end
        S_FULL: begin
          if (ARM) begin
            r_state  <= S_CAPTURE;
            r_done   <= 1'b0;
            r_busy   <= 1'b1;
            r_wr_ptr <= {AW{1'b0}};
            r_count  <= {(AW+1){1'b0}};
          end else if (RD_START) begin
            r_state   <= S_SHIFT;
            r_busy    <= 1'b1;
            r_rd_ptr  <= {AW{1'b0}};
            r_bit_idx <= TOP_BIT;
            r_drain   <= 1'b0;
          end
        end
        S_SHIFT: begin
          if (r_drain) begin
            // Last bit has been on SDO for one cycle: close the frame and release the buffer.
            r_state  <= S_IDLE;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
            r_drain  <= 1'b0;
            r_sdo    <= 1'b0;
            r_sframe <= 1'b0;
            r_svalid <= 1'b0;
          end else begin
            r_svalid <= 1'b1;
            r_sdo    <= w_ram_q[r_bit_idx];
            r_sframe <= (r_bit_idx == TOP_BIT);
            if (w_last_bit) begin
              r_bit_idx <= TOP_BIT;
              r_rd_ptr  <= r_rd_ptr + AW'(1);
              r_drain   <= w_last_word;
            end else begin
              r_bit_idx <= r_bit_idx - BIW'(1);
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign DONE   = r_done;
  assign BUSY   = r_busy & state_is_busy(r_state);
  assign COUNT  = r_count;
  assign SDO    = r_sdo;
  assign SFRAME = r_sframe;
  assign SVALID = r_svalid;

endmodule
